clk_div_multi: RTL

Multi-channel programmable clock-enable and clock generator. It replaces the fixed single-output divider with NUM_CH independent channels, each with a run-time period and high time. Each channel also has a per-channel enable, a glitch-free shadowed config update and a rising-edge tick strobe. It sits between the board oscillator domain and the slow consumers (gray counters, display scan, LED blink), which should use `tick_o` as a clock enable.

---
 rtl/clk_div_pkg.sv | 29 ++
 rtl/clk_div_ch.sv | 127 ++++++++++++
 rtl/clk_div_multi.sv | 90 +++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, types and helpers
// for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned DEF_RST_PERIOD = 5000000;
  localparam int unsigned DEF_RST_HIGH   = DEF_RST_PERIOD / 2;

  // What a channel does on the coming edge.
  typedef enum logic [1:0] {
    CH_OFF,
    CH_SYNC,
    CH_WRAP,
    CH_RUN
  } ch_mode_e;

  // Width of a channel index; never zero.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A config is usable when P >= 2 and 1 <= H <= P-1.
  function automatic logic cfg_legal(
    input logic [63:0] p,
    input logic [63:0] h
  );
    return (p >= 64'd2) && (h >= 64'd1) && (h < p);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with active and
// shadow period/high registers and a tick strobe.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int unsigned RST_PERIOD = DEF_RST_PERIOD,
  parameter int unsigned RST_HIGH   = DEF_RST_HIGH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_high,
  output logic             o_pend,
  output logic             o_clk,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] L_RP = CNT_W'(RST_PERIOD);
  localparam logic [CNT_W-1:0] L_RH = CNT_W'(RST_HIGH);
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_ZERO = '0;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_pper;
  logic [CNT_W-1:0] r_phigh;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;

  ch_mode_e         w_mode;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_per;
  logic [CNT_W-1:0] w_high;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_clk_n;
  logic             w_tick_n;

  // Classify the coming edge: off, sync, wrap or count.
  always_comb begin
    w_wrap = (r_cnt == (r_per - L_ONE));
    w_mode = CH_RUN;
    unique case (1'b1)
      !i_en:                       w_mode = CH_OFF;
      i_en && i_sync:              w_mode = CH_SYNC;
      i_en && !i_sync && w_wrap:   w_mode = CH_WRAP;
      i_en && !i_sync && !w_wrap:  w_mode = CH_RUN;
      default:                     w_mode = CH_RUN;
    endcase
  end

  // Shadow config only lands at a period boundary or while off,
  // so the output never sees a truncated period.
  always_comb begin
    w_apply  = r_pend && (w_mode != CH_RUN);
    w_per    = w_apply ? r_pper  : r_per;
    w_high   = w_apply ? r_phigh : r_high;
    w_cnt_n  = r_cnt;
    w_clk_n  = 1'b0;
    w_tick_n = 1'b0;
    unique case (w_mode)
      CH_OFF: begin
        w_cnt_n  = w_per - L_ONE;
        w_clk_n  = 1'b0;
        w_tick_n = 1'b0;
      end
      CH_SYNC: begin
        w_cnt_n  = L_ZERO;
        w_clk_n  = 1'b1;
        w_tick_n = 1'b1;
      end
      CH_WRAP: begin
        w_cnt_n  = L_ZERO;
        w_clk_n  = (L_ZERO < w_high);
        w_tick_n = 1'b1;
      end
      CH_RUN: begin
        w_cnt_n  = r_cnt + L_ONE;
        w_clk_n  = (w_cnt_n < w_high);
        w_tick_n = 1'b0;
      end
      default: begin
        w_cnt_n  = r_cnt;
        w_clk_n  = 1'b0;
        w_tick_n = 1'b0;
      end
    endcase
  end

  // Channel state; a write never meets a set pend flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt   <= L_RP - L_ONE;
      r_per   <= L_RP;
      r_high  <= L_RH;
      r_pper  <= L_RP;
      r_phigh <= L_RH;
      r_pend  <= 1'b0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_n;
      r_per  <= w_per;
      r_high <= w_high;
      r_clk  <= w_clk_n;
      r_tick <= w_tick_n;
      if (i_wr) begin
        r_pper  <= i_period;
        r_phigh <= i_high;
        r_pend  <= 1'b1;
      end else if (w_apply) begin
        r_pend  <= 1'b0;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_clk  = r_clk;
  assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH programmable clock/tick generators
// sharing one config port with a ready/valid handshake.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int unsigned RST_PERIOD = DEF_RST_PERIOD,
  parameter int unsigned RST_HIGH   = RST_PERIOD / 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_CH-1:0]             en_i,
  input  logic                          sync_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]              cfg_period_i,
  input  logic [CNT_W-1:0]              cfg_high_i,
  output logic                          cfg_err_o,
  output logic [NUM_CH-1:0]             clk_o,
  output logic [NUM_CH-1:0]             tick_o
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_wr;
  logic              w_pend_sel;
  logic              w_ch_ok;
  logic              w_xfer;
  logic              w_legal;
  logic              r_err;

  // Select the addressed channel's pend flag; an index past
  // the last channel is always ready so it can be rejected.
  always_comb begin
    w_pend_sel = 1'b0;
    w_ch_ok    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch_i == CH_W'(i)) begin
        w_pend_sel = w_pend[i];
        w_ch_ok    = 1'b1;
      end
    end
  end

  assign cfg_ready_o = !w_pend_sel;
  assign w_xfer      = cfg_valid_i && cfg_ready_o;
  assign w_legal     = w_ch_ok &&
                       cfg_legal(64'(cfg_period_i),
                                 64'(cfg_high_i));

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_wr[g] = w_xfer && w_legal &&
                       (cfg_ch_i == CH_W'(g));

      clk_div_ch #(
        .CNT_W      (CNT_W),
        .RST_PERIOD (RST_PERIOD),
        .RST_HIGH   (RST_HIGH)
      ) u_ch (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_en     (en_i[g]),
        .i_sync   (sync_i),
        .i_wr     (w_wr[g]),
        .i_period (cfg_period_i),
        .i_high   (cfg_high_i),
        .o_pend   (w_pend[g]),
        .o_clk    (clk_o[g]),
        .o_tick   (tick_o[g])
      );
    end
  endgenerate

  // Rejected transfers report one cycle after they are consumed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_xfer && !w_legal;
    end
  end

  assign cfg_err_o = r_err;

endmodule
